// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: engine handshakes, engine command buses and SDRAM pins around the arbiter.
// Latency: none, wiring only.
// Backpressure: requests are levels held by each engine until the arbiter grants the bus.
interface sdram_arbiter_if #(
    parameter int DQ_W = 16
);
    // init engine
    logic            flag_init_end;
    logic [3:0]      init_cmd;
    logic [12:0]     init_addr;
    // refresh engine
    logic            ref_req;
    logic            aref_en;
    logic            flag_ref_end;
    logic [3:0]      ref_cmd;
    logic [12:0]     ref_addr;
    // write engine
    logic            wr_req;
    logic            wr_en;
    logic            flag_wr_end;
    logic [3:0]      wr_cmd;
    logic [12:0]     wr_addr;
    logic [1:0]      wr_bank;
    logic [DQ_W-1:0] wr_data;
    // read engine
    logic            rd_req;
    logic            rd_en;
    logic            flag_rd_end;
    logic [3:0]      rd_cmd;
    logic [12:0]     rd_addr;
    logic [1:0]      rd_bank;
    // SDRAM pins
    logic            sdram_cke;
    logic            sdram_cs_n;
    logic            sdram_ras_n;
    logic            sdram_cas_n;
    logic            sdram_we_n;
    logic [1:0]      sdram_bank;
    logic [12:0]     sdram_addr;
    logic [DQ_W-1:0] sdram_dq_out;
    logic            sdram_dq_oe;

    // arbiter side
    modport slave (
        input  flag_init_end, init_cmd, init_addr,
        output ref_req, aref_en,
        input  flag_ref_end, ref_cmd, ref_addr,
        input  wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank, wr_data,
        output wr_en,
        input  rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
        output rd_en,
        output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        output sdram_bank, sdram_addr, sdram_dq_out, sdram_dq_oe
    );

    // engines / pin side
    modport master (
        output flag_init_end, init_cmd, init_addr,
        input  ref_req, aref_en,
        output flag_ref_end, ref_cmd, ref_addr,
        output wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank, wr_data,
        input  wr_en,
        output rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
        input  rd_en,
        input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        input  sdram_bank, sdram_addr, sdram_dq_out, sdram_dq_oe
    );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: owns the SDRAM pins, fixed priority refresh > write > read; read path only with SDRAM_ARB_RD_EN.
// Latency: request seen in IDLE -> state, grant pulse and pin mux switch one sclk later.
// Backpressure: requests wait as levels; a granted engine keeps the bus until its end pulse.
module sdram_arbiter #(
    parameter int REF_CNT_MAX = 749
) (
    input  logic           sclk,
    input  logic           s_rst_n,
    sdram_arbiter_if.slave bus
);
    localparam logic [4:0] INIT  = 5'b00001;
    localparam logic [4:0] IDLE  = 5'b00010;
    localparam logic [4:0] AREF  = 5'b00100;
    localparam logic [4:0] WRITE = 5'b01000;
    localparam logic [4:0] READ  = 5'b10000;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [9:0] REF_MAX = 10'(REF_CNT_MAX);

    logic [4:0] state;
    logic [4:0] state_nxt;
    logic [9:0] ref_cnt;
    logic       ref_req;
    logic       aref_en;
    logic       wr_en;
    logic       cke;
    logic       rd_pick;
    logic [3:0] cmd;

`ifdef SDRAM_ARB_RD_EN
    logic rd_en;
    assign rd_pick = bus.rd_req;
`else
    // Read engine absent: its inputs are deliberately dropped.
    logic unused_rd;
    assign rd_pick   = 1'b0;
    assign unused_rd = ^{bus.rd_req, bus.flag_rd_end, bus.rd_cmd, bus.rd_addr, bus.rd_bank};
`endif

    // Next-state: fixed priority out of IDLE, granted engine holds until its end pulse.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (bus.flag_init_end) state_nxt = IDLE;
            IDLE: begin
                if (ref_req)         state_nxt = AREF;
                else if (bus.wr_req) state_nxt = WRITE;
                else if (rd_pick)    state_nxt = READ;
            end
            AREF:    if (bus.flag_ref_end) state_nxt = IDLE;
            WRITE:   if (bus.flag_wr_end)  state_nxt = IDLE;
`ifdef SDRAM_ARB_RD_EN
            READ:    if (bus.flag_rd_end)  state_nxt = IDLE;
`endif
            default: state_nxt = INIT;
        endcase
    end

    // State register; reset drops any grant in progress.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) state <= INIT;
        else          state <= state_nxt;
    end

    // Refresh interval timer, idle until init is done, free-running afterwards.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n)                ref_cnt <= '0;
        else if (state == INIT)      ref_cnt <= '0;
        else if (ref_cnt == REF_MAX) ref_cnt <= '0;
        else                         ref_cnt <= ref_cnt + 10'd1;
    end

    // Refresh request: set on wrap, consumed by the grant; a wrap while pending does not stack.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n)                        ref_req <= 1'b0;
        else if ((state == IDLE) && ref_req) ref_req <= 1'b0;
        else if (ref_cnt == REF_MAX)         ref_req <= 1'b1;
    end

    // One-cycle grant pulses coincide with the first cycle of the granted state.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            aref_en <= 1'b0;
            wr_en   <= 1'b0;
        end else begin
            aref_en <= (state == IDLE) && (state_nxt == AREF);
            wr_en   <= (state == IDLE) && (state_nxt == WRITE);
        end
    end

`ifdef SDRAM_ARB_RD_EN
    // Read grant pulse.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) rd_en <= 1'b0;
        else          rd_en <= (state == IDLE) && (state_nxt == READ);
    end
    assign bus.rd_en = rd_en;
`else
    assign bus.rd_en = 1'b0;
`endif

    // Clock enable comes up on the first edge after reset release.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) cke <= 1'b0;
        else          cke <= 1'b1;
    end

    // Pin mux on state; INIT only drives the init engine once cke is up so reset shows NOP.
    always_comb begin
        cmd              = CMD_NOP;
        bus.sdram_addr   = '0;
        bus.sdram_bank   = '0;
        bus.sdram_dq_out = '0;
        bus.sdram_dq_oe  = 1'b0;
        case (state)
            INIT: if (cke) begin
                cmd            = bus.init_cmd;
                bus.sdram_addr = bus.init_addr;
            end
            AREF: begin
                cmd            = bus.ref_cmd;
                bus.sdram_addr = bus.ref_addr;
            end
            WRITE: begin
                cmd              = bus.wr_cmd;
                bus.sdram_addr   = bus.wr_addr;
                bus.sdram_bank   = bus.wr_bank;
                bus.sdram_dq_out = bus.wr_data;
                bus.sdram_dq_oe  = 1'b1;
            end
`ifdef SDRAM_ARB_RD_EN
            READ: begin
                cmd            = bus.rd_cmd;
                bus.sdram_addr = bus.rd_addr;
                bus.sdram_bank = bus.rd_bank;
            end
`endif
            default: ;
        endcase
    end

    assign {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = cmd;
    assign bus.sdram_cke = cke;
    assign bus.ref_req   = ref_req;
    assign bus.aref_en   = aref_en;
    assign bus.wr_en     = wr_en;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed scenarios for the SDRAM arbiter with hand-derived expectations.
// Latency: inputs driven on the falling edge, outputs sampled on the falling edge.
// Backpressure: every wait on the DUT is bounded.
module tb_sdram_arbiter;
    logic sclk;
    logic s_rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    sdram_arbiter_if #(.DQ_W(16)) bus();

    sdram_arbiter #(.REF_CNT_MAX(749)) dut (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .bus     (bus)
    );

    localparam logic [3:0]  INIT_CMD  = 4'b0010;
    localparam logic [3:0]  REF_CMD   = 4'b0001;
    localparam logic [3:0]  WR_CMD    = 4'b0100;
    localparam logic [3:0]  RD_CMD    = 4'b0101;
    localparam logic [12:0] INIT_ADDR = 13'h0400;
    localparam logic [12:0] REF_ADDR  = 13'h0011;
    localparam logic [12:0] WR_ADDR   = 13'h0123;
    localparam logic [12:0] RD_ADDR   = 13'h0456;
    localparam logic [15:0] WR_DATA   = 16'hA5C3;

    // {cmd, addr, bank, dq_oe, dq_out}
    localparam logic [35:0] PINS_NOP  = {4'b0111, 13'h0, 2'd0, 1'b0, 16'h0};
    localparam logic [35:0] PINS_INIT = {INIT_CMD, INIT_ADDR, 2'd0, 1'b0, 16'h0};
    localparam logic [35:0] PINS_REF  = {REF_CMD, REF_ADDR, 2'd0, 1'b0, 16'h0};
    localparam logic [35:0] PINS_WR   = {WR_CMD, WR_ADDR, 2'd2, 1'b1, WR_DATA};
    localparam logic [35:0] PINS_RD   = {RD_CMD, RD_ADDR, 2'd1, 1'b0, 16'h0};

    logic [35:0] pins;
    logic [2:0]  grants;
    assign pins   = {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n,
                     bus.sdram_addr, bus.sdram_bank, bus.sdram_dq_oe, bus.sdram_dq_out};
    assign grants = {bus.aref_en, bus.wr_en, bus.rd_en};

    initial sclk = 1'b0;
    always #10 sclk = ~sclk;

    initial begin
        #(20 * 20000);
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic test_reset;
        s_rst_n = 1'b0;
        step(3);
        n_cmp++;
        if (pins !== PINS_NOP) begin
            n_err++; $display("FAIL reset_pins: got %h want %h", pins, PINS_NOP);
        end
        n_cmp++;
        if ({bus.sdram_cke, bus.ref_req, grants} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctl: got %b want 00000", {bus.sdram_cke, bus.ref_req, grants});
        end
        s_rst_n = 1'b1;
        step(1);
        n_cmp++;
        if ({bus.sdram_cke, pins} !== {1'b1, PINS_INIT}) begin
            n_err++; $display("FAIL cke_init: got %h want %h", {bus.sdram_cke, pins}, {1'b1, PINS_INIT});
        end
    endtask

    task automatic test_init_timer;
        logic early;
        step(8);
        bus.flag_init_end = 1'b1;
        n_cmp++;
        if (pins !== PINS_INIT) begin
            n_err++; $display("FAIL init_hold: got %h want %h", pins, PINS_INIT);
        end
        step(1);
        n_cmp++;
        if (pins !== PINS_NOP) begin
            n_err++; $display("FAIL init_to_idle: got %h want %h", pins, PINS_NOP);
        end
        early = 1'b0;
        for (int i = 0; i < 749; i++) begin
            step(1);
            if (bus.ref_req !== 1'b0) early = 1'b1;
        end
        n_cmp++;
        if (early !== 1'b0) begin
            n_err++; $display("FAIL ref_req_early: got %b want 0", early);
        end
        step(1);
        n_cmp++;
        if (bus.ref_req !== 1'b1) begin
            n_err++; $display("FAIL ref_req_750: got %b want 1", bus.ref_req);
        end
    endtask

    task automatic test_refresh;
        step(1);
        n_cmp++;
        if ({grants, bus.ref_req, pins} !== {3'b100, 1'b0, PINS_REF}) begin
            n_err++; $display("FAIL aref_grant: got %h want %h", {grants, bus.ref_req, pins}, {3'b100, 1'b0, PINS_REF});
        end
        step(1);
        n_cmp++;
        if ({grants, pins} !== {3'b000, PINS_REF}) begin
            n_err++; $display("FAIL aref_pulse_once: got %h want %h", {grants, pins}, {3'b000, PINS_REF});
        end
        bus.flag_ref_end = 1'b1;
        step(1);
        bus.flag_ref_end = 1'b0;
        n_cmp++;
        if (pins !== PINS_NOP) begin
            n_err++; $display("FAIL aref_release: got %h want %h", pins, PINS_NOP);
        end
    endtask

    task automatic test_write;
        bus.wr_req = 1'b1;
        step(1);
        n_cmp++;
        if ({grants, pins} !== {3'b010, PINS_WR}) begin
            n_err++; $display("FAIL wr_grant: got %h want %h", {grants, pins}, {3'b010, PINS_WR});
        end
        step(1);
        n_cmp++;
        if ({grants, pins} !== {3'b000, PINS_WR}) begin
            n_err++; $display("FAIL wr_pulse_once: got %h want %h", {grants, pins}, {3'b000, PINS_WR});
        end
        bus.wr_req      = 1'b0;
        bus.flag_wr_end = 1'b1;
        step(1);
        bus.flag_wr_end = 1'b0;
        n_cmp++;
        if ({grants, pins} !== {3'b000, PINS_NOP}) begin
            n_err++; $display("FAIL wr_release: got %h want %h", {grants, pins}, {3'b000, PINS_NOP});
        end
    endtask

    task automatic test_ref_wr_same;
        logic found;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            step(1);
            if (bus.ref_req === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (found !== 1'b1) begin
            n_err++; $display("FAIL ref_req_second: got %b want 1", found);
        end
        bus.wr_req = 1'b1;
        step(1);
        n_cmp++;
        if ({grants, bus.ref_req, pins} !== {3'b100, 1'b0, PINS_REF}) begin
            n_err++; $display("FAIL ref_beats_wr: got %h want %h", {grants, bus.ref_req, pins}, {3'b100, 1'b0, PINS_REF});
        end
        step(2);
        bus.flag_ref_end = 1'b1;
        step(1);
        bus.flag_ref_end = 1'b0;
        n_cmp++;
        if ({grants, pins} !== {3'b000, PINS_NOP}) begin
            n_err++; $display("FAIL idle_gap: got %h want %h", {grants, pins}, {3'b000, PINS_NOP});
        end
        step(1);
        n_cmp++;
        if ({grants, pins} !== {3'b010, PINS_WR}) begin
            n_err++; $display("FAIL wr_after_ref: got %h want %h", {grants, pins}, {3'b010, PINS_WR});
        end
    endtask

    task automatic test_ref_during_write;
        logic found;
        bus.rd_req = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            step(1);
            if (bus.ref_req === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if ({found, pins} !== {1'b1, PINS_WR}) begin
            n_err++; $display("FAIL ref_in_write: got %h want %h", {found, pins}, {1'b1, PINS_WR});
        end
        step(3);
        n_cmp++;
        if ({bus.ref_req, grants, pins} !== {1'b1, 3'b000, PINS_WR}) begin
            n_err++; $display("FAIL ref_deferred: got %h want %h", {bus.ref_req, grants, pins}, {1'b1, 3'b000, PINS_WR});
        end
        bus.flag_wr_end = 1'b1;
        step(1);
        bus.flag_wr_end = 1'b0;
        n_cmp++;
        if ({bus.ref_req, pins} !== {1'b1, PINS_NOP}) begin
            n_err++; $display("FAIL yield_idle: got %h want %h", {bus.ref_req, pins}, {1'b1, PINS_NOP});
        end
        step(1);
        n_cmp++;
        if ({grants, bus.ref_req, pins} !== {3'b100, 1'b0, PINS_REF}) begin
            n_err++; $display("FAIL ref_over_wr_rd: got %h want %h", {grants, bus.ref_req, pins}, {3'b100, 1'b0, PINS_REF});
        end
        bus.flag_ref_end = 1'b1;
        step(1);
        bus.flag_ref_end = 1'b0;
        step(1);
        n_cmp++;
        if ({grants, pins} !== {3'b010, PINS_WR}) begin
            n_err++; $display("FAIL wr_before_rd: got %h want %h", {grants, pins}, {3'b010, PINS_WR});
        end
    endtask

    task automatic test_write_read;
        logic stray;
        bus.wr_req      = 1'b0;
        bus.flag_wr_end = 1'b1;
        step(1);
        bus.flag_wr_end = 1'b0;
        step(1);
`ifdef SDRAM_ARB_RD_EN
        n_cmp++;
        if ({grants, pins} !== {3'b001, PINS_RD}) begin
            n_err++; $display("FAIL rd_grant: got %h want %h", {grants, pins}, {3'b001, PINS_RD});
        end
        step(1);
        bus.rd_req      = 1'b0;
        bus.flag_rd_end = 1'b1;
        step(1);
        bus.flag_rd_end = 1'b0;
        n_cmp++;
        if ({grants, pins} !== {3'b000, PINS_NOP}) begin
            n_err++; $display("FAIL rd_release: got %h want %h", {grants, pins}, {3'b000, PINS_NOP});
        end
        stray = 1'b0;
`else
        stray = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (grants !== 3'b000 || pins !== PINS_NOP) stray = 1'b1;
            step(1);
        end
        bus.rd_req = 1'b0;
`endif
        n_cmp++;
        if (stray !== 1'b0) begin
            n_err++; $display("FAIL rd_disabled: got %b want 0", stray);
        end
    endtask

    task automatic test_reset_mid_write;
        bus.wr_req = 1'b1;
        step(1);
        n_cmp++;
        if ({grants, pins} !== {3'b010, PINS_WR}) begin
            n_err++; $display("FAIL pre_reset_wr: got %h want %h", {grants, pins}, {3'b010, PINS_WR});
        end
        #5 s_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.sdram_cke, bus.ref_req, grants, pins} !== {5'b0, PINS_NOP}) begin
            n_err++; $display("FAIL async_reset: got %h want %h", {bus.sdram_cke, bus.ref_req, grants, pins}, {5'b0, PINS_NOP});
        end
        bus.flag_init_end = 1'b0;
        step(1);
        s_rst_n = 1'b1;
        step(1);
        n_cmp++;
        if ({bus.sdram_cke, grants, pins} !== {1'b1, 3'b000, PINS_INIT}) begin
            n_err++; $display("FAIL reinit: got %h want %h", {bus.sdram_cke, grants, pins}, {1'b1, 3'b000, PINS_INIT});
        end
        step(3);
        n_cmp++;
        if ({grants, pins} !== {3'b000, PINS_INIT}) begin
            n_err++; $display("FAIL init_ignores_wr: got %h want %h", {grants, pins}, {3'b000, PINS_INIT});
        end
        bus.flag_init_end = 1'b1;
        step(1);
        n_cmp++;
        if (pins !== PINS_NOP) begin
            n_err++; $display("FAIL reinit_idle: got %h want %h", pins, PINS_NOP);
        end
        step(1);
        n_cmp++;
        if ({grants, pins} !== {3'b010, PINS_WR}) begin
            n_err++; $display("FAIL wr_after_reinit: got %h want %h", {grants, pins}, {3'b010, PINS_WR});
        end
        bus.wr_req      = 1'b0;
        bus.flag_wr_end = 1'b1;
        step(1);
        bus.flag_wr_end = 1'b0;
    endtask

    initial begin
        s_rst_n           = 1'b0;
        bus.flag_init_end = 1'b0;
        bus.init_cmd      = INIT_CMD;
        bus.init_addr     = INIT_ADDR;
        bus.flag_ref_end  = 1'b0;
        bus.ref_cmd       = REF_CMD;
        bus.ref_addr      = REF_ADDR;
        bus.wr_req        = 1'b0;
        bus.flag_wr_end   = 1'b0;
        bus.wr_cmd        = WR_CMD;
        bus.wr_addr       = WR_ADDR;
        bus.wr_bank       = 2'd2;
        bus.wr_data       = WR_DATA;
        bus.rd_req        = 1'b0;
        bus.flag_rd_end   = 1'b0;
        bus.rd_cmd        = RD_CMD;
        bus.rd_addr       = RD_ADDR;
        bus.rd_bank       = 2'd1;

        test_reset();
        test_init_timer();
        test_refresh();
        test_write();
        test_ref_wr_same();
        test_ref_during_write();
        test_write_read();
        test_reset_mid_write();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
